// File: rtl/wd_burst_tracker.sv
// W-channel burst tracker: queues AW burst lengths, counts W beats against the
// head burst, checks WLAST placement and pulses completion/error flags.
module wd_burst_tracker #(
    parameter int LEN_W  = 8,
    parameter int DEPTH  = 4,
    parameter bit STRICT = 1'b1
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       aw_valid,
    input  logic                       aw_ready,
    input  logic [LEN_W-1:0]           aw_len,
    output logic                       aw_accept,
    input  logic                       w_valid,
    input  logic                       w_ready,
    input  logic                       w_last,
    output logic                       w_allow,
    output logic                       w_last_exp,
    output logic                       burst_done,
    output logic                       last_err,
    output logic                       err_sticky,
    output logic [LEN_W-1:0]           beat_cnt,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       state_dbg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    // Handshake rule: a transfer happens only on a cycle where valid, ready
    // and the tracker's own permit (aw_accept / w_allow) are all high.

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0] len_mem [DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic [LEN_W-1:0] head_len;
    logic             full;
    logic             push, beat, pop, mismatch;

    assign outstanding = wr_ptr - rd_ptr;
    assign full        = (outstanding == FULL_CNT);
    assign aw_accept   = !full;
    assign push        = aw_valid && aw_ready && aw_accept;

    assign head_len    = len_mem[rd_ptr[PTR_W-1:0]];
    assign w_allow     = (state == ACTIVE);
    assign w_last_exp  = w_allow && (beat_cnt == head_len);
    assign beat        = w_valid && w_ready && w_allow;

    // In non-strict mode an early WLAST also terminates the head burst.
    assign pop      = beat && (w_last_exp || (!STRICT && w_last));
    assign mismatch = beat && (w_last != w_last_exp);

    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (push) state_nxt = ACTIVE;
            ACTIVE:  if (pop && (outstanding == ONE_CNT) && !push) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            beat_cnt   <= '0;
            burst_done <= 1'b0;
            last_err   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_nxt;
            burst_done <= pop;
            last_err   <= mismatch;
            if (mismatch) err_sticky <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Length storage needs no reset: entries are only read once pushed.
    always_ff @(posedge ACLK) begin
        if (push) len_mem[wr_ptr[PTR_W-1:0]] <= aw_len;
    end

endmodule

// File: tb/tb_wd_burst_tracker.sv
// Directed bench for wd_burst_tracker: a STRICT=1 and a STRICT=0 instance share
// stimulus and are checked every cycle against a queue-based reference model.
module tb_wd_burst_tracker;

    localparam int LEN_W = 8;
    localparam int DEPTH = 4;

    logic ACLK, ARESET;
    logic aw_valid, aw_ready, w_valid, w_ready, w_last;
    logic [LEN_W-1:0] aw_len;

    logic       acc_s   [2];
    logic       allow_s [2];
    logic       lexp_s  [2];
    logic       done_s  [2];
    logic       err_s   [2];
    logic       stk_s   [2];
    logic [7:0] cnt_s   [2];
    logic [2:0] out_s   [2];
    logic       st_s    [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    // reference model state, index 0 = STRICT=1, index 1 = STRICT=0
    int mq [2][$];
    int m_cnt [2];
    bit m_done [2];
    bit m_err [2];
    bit m_stk [2];

    wd_burst_tracker #(.LEN_W(LEN_W), .DEPTH(DEPTH), .STRICT(1'b1)) dut_strict (
        .ACLK(ACLK), .ARESET(ARESET),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_len(aw_len), .aw_accept(acc_s[0]),
        .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last),
        .w_allow(allow_s[0]), .w_last_exp(lexp_s[0]), .burst_done(done_s[0]),
        .last_err(err_s[0]), .err_sticky(stk_s[0]), .beat_cnt(cnt_s[0]),
        .outstanding(out_s[0]), .state_dbg(st_s[0])
    );

    wd_burst_tracker #(.LEN_W(LEN_W), .DEPTH(DEPTH), .STRICT(1'b0)) dut_loose (
        .ACLK(ACLK), .ARESET(ARESET),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_len(aw_len), .aw_accept(acc_s[1]),
        .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last),
        .w_allow(allow_s[1]), .w_last_exp(lexp_s[1]), .burst_done(done_s[1]),
        .last_err(err_s[1]), .err_sticky(stk_s[1]), .beat_cnt(cnt_s[1]),
        .outstanding(out_s[1]), .state_dbg(st_s[1])
    );

    // clock / reset
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: burst bookkeeping expressed as a queue of lengths
    always @(posedge ACLK) begin
        for (int m = 0; m < 2; m++) begin
            if (ARESET) begin
                mq[m].delete();
                m_cnt[m] = 0;
                m_done[m] = 0;
                m_err[m] = 0;
                m_stk[m] = 0;
            end else begin
                bit allow, was_full, exp_last, nd, ne;
                allow    = (mq[m].size() > 0);
                was_full = (mq[m].size() == DEPTH);
                exp_last = allow && (m_cnt[m] == mq[m][0]);
                nd = 0;
                ne = 0;
                if (w_valid && w_ready && allow) begin
                    if (w_last != exp_last) ne = 1;
                    if (exp_last || (m == 1 && w_last)) begin
                        void'(mq[m].pop_front());
                        m_cnt[m] = 0;
                        nd = 1;
                    end else begin
                        m_cnt[m]++;
                    end
                end
                if (aw_valid && aw_ready && !was_full) mq[m].push_back(int'(aw_len));
                m_done[m] = nd;
                m_err[m]  = ne;
                if (ne) m_stk[m] = 1;
            end
        end
    end

    // scoreboard compare, every cycle away from the active edge
    always @(negedge ACLK) begin
        if (cmp_en) begin
            for (int m = 0; m < 2; m++) begin
                int sz;
                sz = mq[m].size();
                chk($sformatf("d%0d aw_accept", m), int'(acc_s[m]), int'(sz < DEPTH));
                chk($sformatf("d%0d w_allow", m), int'(allow_s[m]), int'(sz > 0));
                chk($sformatf("d%0d state", m), int'(st_s[m]), int'(sz > 0));
                chk($sformatf("d%0d w_last_exp", m), int'(lexp_s[m]),
                    int'(sz > 0 && m_cnt[m] == mq[m][0]));
                chk($sformatf("d%0d beat_cnt", m), int'(cnt_s[m]), m_cnt[m]);
                chk($sformatf("d%0d outstanding", m), int'(out_s[m]), sz);
                chk($sformatf("d%0d burst_done", m), int'(done_s[m]), int'(m_done[m]));
                chk($sformatf("d%0d last_err", m), int'(err_s[m]), int'(m_err[m]));
                chk($sformatf("d%0d err_sticky", m), int'(stk_s[m]), int'(m_stk[m]));
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic idle_in();
        aw_valid = 0; aw_ready = 0; aw_len = '0;
        w_valid = 0; w_ready = 0; w_last = 0;
    endtask

    task automatic do_reset();
        idle_in();
        ARESET = 1;
        step();
        step();
        ARESET = 0;
    endtask

    task automatic push(input int len);
        aw_valid = 1; aw_ready = 1; aw_len = LEN_W'(len);
        step();
        aw_valid = 0; aw_ready = 0;
    endtask

    task automatic w_beat(input bit last);
        w_valid = 1; w_ready = 1; w_last = last;
        step();
        w_valid = 0; w_ready = 0; w_last = 0;
    endtask

    initial begin
        ARESET = 1;
        idle_in();
        step();
        cmp_en = 1;
        do_reset();
        chk("rst outstanding", int'(out_s[0]), 0);
        chk("rst aw_accept", int'(acc_s[0]), 1);
        chk("rst w_allow", int'(allow_s[0]), 0);

        // single-beat burst
        push(0);
        chk("t1 outstanding", int'(out_s[0]), 1);
        chk("t1 w_last_exp", int'(lexp_s[0]), 1);
        w_beat(1);
        chk("t1 done", int'(done_s[0]), 1);
        chk("t1 last_err", int'(err_s[0]), 0);
        chk("t1 outstanding after", int'(out_s[0]), 0);
        step();
        chk("t1 done drops", int'(done_s[0]), 0);

        // four-beat burst, beat_cnt 1,2,3,0
        push(3);
        for (int k = 1; k <= 4; k++) begin
            w_beat(k == 4);
            chk("t2 beat_cnt", int'(cnt_s[0]), k % 4);
            chk("t2 done", int'(done_s[0]), int'(k == 4));
        end
        chk("t2 sticky", int'(stk_s[0]), 0);

        // early WLAST on beat 2; a second burst queued behind
        do_reset();
        push(3);
        push(1);
        for (int k = 1; k <= 4; k++) begin
            w_beat(k == 2);
            if (k == 2) begin
                chk("t3 strict err", int'(err_s[0]), 1);
                chk("t3 strict no done", int'(done_s[0]), 0);
                chk("t3 loose done", int'(done_s[1]), 1);
                chk("t3 loose err", int'(err_s[1]), 1);
                chk("t3 loose next head", int'(out_s[1]), 1);
            end
        end
        chk("t3 strict done at 4", int'(done_s[0]), 1);
        chk("t3 strict sticky", int'(stk_s[0]), 1);

        // fill, blocked push, push/pop interaction
        do_reset();
        for (int k = 0; k < 4; k++) push(1);
        chk("t4 full outstanding", int'(out_s[0]), 4);
        chk("t4 aw_accept low", int'(acc_s[0]), 0);
        push(2);
        chk("t4 blocked push", int'(out_s[0]), 4);
        w_beat(0);
        aw_valid = 1; aw_ready = 1; aw_len = 8'd2;
        w_beat(1);
        chk("t4 pop while full", int'(out_s[0]), 3);
        aw_valid = 0;
        w_beat(0);
        aw_valid = 1;
        w_beat(1);
        chk("t4 push+pop", int'(out_s[0]), 3);
        step();
        aw_valid = 0; aw_ready = 0;
        chk("t4 refill", int'(out_s[0]), 4);

        // back-to-back two-beat bursts
        do_reset();
        for (int k = 0; k < 3; k++) push(1);
        w_valid = 1; w_ready = 1;
        for (int k = 1; k <= 6; k++) begin
            w_last = (k % 2 == 0);
            step();
            chk("t5 done pattern", int'(done_s[0]), int'(k % 2 == 0));
        end
        idle_in();
        chk("t5 drained", int'(out_s[0]), 0);

        // reset mid-burst, then normal operation
        do_reset();
        push(3);
        w_beat(0);
        w_beat(0);
        chk("t6 beat_cnt", int'(cnt_s[0]), 2);
        ARESET = 1; w_valid = 1; w_ready = 1;
        step();
        ARESET = 0; w_valid = 0; w_ready = 0;
        chk("t6 rst beat_cnt", int'(cnt_s[0]), 0);
        chk("t6 rst outstanding", int'(out_s[0]), 0);
        chk("t6 rst done", int'(done_s[0]), 0);
        chk("t6 rst w_allow", int'(allow_s[0]), 0);
        w_valid = 1; w_ready = 1; w_last = 1;
        push(0);
        w_valid = 0; w_ready = 0; w_last = 0;
        chk("t6 beat on push ignored", int'(out_s[0]), 1);
        w_beat(1);
        chk("t6 done", int'(done_s[0]), 1);
        step();

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
